// File: rtl/mem_sched_pkg.sv
// Shared types for the memory request scheduler.
//   sched_state_t : scheduler FSM states
//   req_src_t     : which requester owns the latched transaction
//   GNT_*         : bit positions inside the one-hot arbiter grant vector
package mem_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} sched_state_t;

  typedef enum logic [1:0] {REQ_NONE, REQ_IC, REQ_DC_RD, REQ_DC_WR} req_src_t;

  localparam int GNT_IC    = 0;
  localparam int GNT_DC_RD = 1;
  localparam int GNT_DC_WR = 2;

endpackage

// File: rtl/mem_req_scheduler_if.sv
// Bundle of the cache-side request/response channels and the memory port
// of the scheduler.
//   slave  : the scheduler's view (takes cache requests and memory responses,
//            drives readies, cache responses and the memory request)
//   master : the surrounding system's view (caches plus main memory)
interface mem_req_scheduler_if #(
  parameter int ADDR_W   = 32,
  parameter int BLOCK_DW = 256
);

  logic                icache_rd_valid_i;
  logic                icache_rd_ready_o;
  logic [ADDR_W-1:0]   icache_rd_addr_i;
  logic                dcache_rd_valid_i;
  logic                dcache_rd_ready_o;
  logic [ADDR_W-1:0]   dcache_rd_addr_i;
  logic                dcache_wr_valid_i;
  logic                dcache_wr_ready_o;
  logic [ADDR_W-1:0]   dcache_wr_addr_i;
  logic [BLOCK_DW-1:0] dcache_wr_data_i;
  logic                icache_resp_valid_o;
  logic [BLOCK_DW-1:0] icache_resp_data_o;
  logic                dcache_resp_valid_o;
  logic [ADDR_W-1:0]   dcache_resp_addr_o;
  logic [BLOCK_DW-1:0] dcache_resp_data_o;
  logic                mem_req_o;
  logic                mem_we_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [BLOCK_DW-1:0] mem_wdata_o;
  logic                mem_gnt_i;
  logic                mem_rvalid_i;
  logic [BLOCK_DW-1:0] mem_rdata_i;
  logic                busy_o;
  logic                err_o;

  modport slave (
    input  icache_rd_valid_i, icache_rd_addr_i,
    input  dcache_rd_valid_i, dcache_rd_addr_i,
    input  dcache_wr_valid_i, dcache_wr_addr_i, dcache_wr_data_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output icache_rd_ready_o, dcache_rd_ready_o, dcache_wr_ready_o,
    output icache_resp_valid_o, icache_resp_data_o,
    output dcache_resp_valid_o, dcache_resp_addr_o, dcache_resp_data_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output busy_o, err_o
  );

  modport master (
    output icache_rd_valid_i, icache_rd_addr_i,
    output dcache_rd_valid_i, dcache_rd_addr_i,
    output dcache_wr_valid_i, dcache_wr_addr_i, dcache_wr_data_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  icache_rd_ready_o, dcache_rd_ready_o, dcache_wr_ready_o,
    input  icache_resp_valid_o, icache_resp_data_o,
    input  dcache_resp_valid_o, dcache_resp_addr_o, dcache_resp_data_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  busy_o, err_o
  );

endinterface

// File: rtl/mem_sched_arbiter.sv
// Fixed-priority arbiter with icache aging.
// Ports:
//   clk_i, rst_i     : clock, async active-high reset
//   arb_en_i         : scheduler is idle and may accept a request
//   ic_valid_i       : icache read pending
//   dc_rd_valid_i    : dcache read pending
//   dc_wr_valid_i    : dcache write-back pending
//   grant_o          : one-hot grant, indexed by GNT_* from the package
//   src_o            : the same grant encoded as req_src_t
module mem_sched_arbiter
  import mem_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       arb_en_i,
  input  logic       ic_valid_i,
  input  logic       dc_rd_valid_i,
  input  logic       dc_wr_valid_i,
  output logic [2:0] grant_o,
  output req_src_t   src_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == LIMIT);

  // Write-back beats read so a dirty block reaches memory before it is
  // re-fetched; a starved icache overrides both.
  always_comb begin
    grant_o = '0;
    src_o   = REQ_NONE;
    if (arb_en_i) begin
      if (ic_valid_i && starved) begin
        grant_o[GNT_IC] = 1'b1;
        src_o           = REQ_IC;
      end else if (dc_wr_valid_i) begin
        grant_o[GNT_DC_WR] = 1'b1;
        src_o              = REQ_DC_WR;
      end else if (dc_rd_valid_i) begin
        grant_o[GNT_DC_RD] = 1'b1;
        src_o              = REQ_DC_RD;
      end else if (ic_valid_i) begin
        grant_o[GNT_IC] = 1'b1;
        src_o           = REQ_IC;
      end
    end
  end

  // Counts arbitrations the icache loses while it is asking; saturates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (grant_o[GNT_IC]) begin
      starve_cnt <= '0;
    end else if (arb_en_i && ic_valid_i && !starved) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_req_scheduler.sv
// Serialises icache reads, dcache reads and dcache write-backs onto one
// single-port main memory with one transaction in flight.
// Ports:
//   clk_i, rst_i : clock, async active-high reset
//   bus          : cache request/response channels, memory port, busy/err
//                  (see mem_req_scheduler_if)
module mem_req_scheduler
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int BLOCK_DW     = 256,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_req_scheduler_if.slave bus
);

  localparam int OFF_W = $clog2(BLOCK_DW / 8);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((1 << OFF_W) - 1);

  sched_state_t        state, state_next;
  logic [2:0]          grant;
  req_src_t            grant_src;
  logic                accept;
  logic [ADDR_W-1:0]   sel_addr;
  logic [BLOCK_DW-1:0] sel_wdata;

  req_src_t            req_src;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [BLOCK_DW-1:0] req_wdata;

  logic                ic_resp_valid;
  logic [BLOCK_DW-1:0] ic_resp_data;
  logic                dc_resp_valid;
  logic [ADDR_W-1:0]   dc_resp_addr;
  logic [BLOCK_DW-1:0] dc_resp_data;
  logic                err;
  logic                rd_done;

  mem_sched_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .arb_en_i      (state == IDLE),
    .ic_valid_i    (bus.icache_rd_valid_i),
    .dc_rd_valid_i (bus.dcache_rd_valid_i),
    .dc_wr_valid_i (bus.dcache_wr_valid_i),
    .grant_o       (grant),
    .src_o         (grant_src)
  );

  assign accept  = (grant_src != REQ_NONE);
  assign rd_done = (state == WAIT_RD) && bus.mem_rvalid_i;

  // Arbiter only grants in IDLE, so the readies are the grant itself.
  assign bus.icache_rd_ready_o = grant[GNT_IC];
  assign bus.dcache_rd_ready_o = grant[GNT_DC_RD];
  assign bus.dcache_wr_ready_o = grant[GNT_DC_WR];

  // Address/data of whichever requester just won.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    case (grant_src)
      REQ_IC:    sel_addr = bus.icache_rd_addr_i;
      REQ_DC_RD: sel_addr = bus.dcache_rd_addr_i;
      REQ_DC_WR: begin
        sel_addr  = bus.dcache_wr_addr_i;
        sel_wdata = bus.dcache_wr_data_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   if (bus.mem_gnt_i) state_next = req_we ? IDLE : WAIT_RD;
      WAIT_RD: if (bus.mem_rvalid_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request register: loaded only on acceptance so the memory side sees a
  // stable request for however long the grant takes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_src   <= REQ_NONE;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (state == IDLE && accept) begin
      req_src   <= grant_src;
      req_we    <= (grant_src == REQ_DC_WR);
      req_addr  <= sel_addr & ADDR_MASK;
      req_wdata <= sel_wdata;
    end
  end

  // Response registers: pulses last one cycle, data is held until the next
  // response for the same cache.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ic_resp_valid <= 1'b0;
      ic_resp_data  <= '0;
      dc_resp_valid <= 1'b0;
      dc_resp_addr  <= '0;
      dc_resp_data  <= '0;
    end else begin
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;
      if (rd_done) begin
        if (req_src == REQ_IC) begin
          ic_resp_valid <= 1'b1;
          ic_resp_data  <= bus.mem_rdata_i;
        end else begin
          dc_resp_valid <= 1'b1;
          dc_resp_addr  <= req_addr;
          dc_resp_data  <= bus.mem_rdata_i;
        end
      end
    end
  end

  // Read data nobody is waiting for is dropped but remembered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err <= 1'b0;
    end else if (bus.mem_rvalid_i && state != WAIT_RD) begin
      err <= 1'b1;
    end
  end

  assign bus.mem_req_o           = (state == ISSUE);
  assign bus.mem_we_o            = req_we;
  assign bus.mem_addr_o          = req_addr;
  assign bus.mem_wdata_o         = req_wdata;
  assign bus.icache_resp_valid_o = ic_resp_valid;
  assign bus.icache_resp_data_o  = ic_resp_data;
  assign bus.dcache_resp_valid_o = dc_resp_valid;
  assign bus.dcache_resp_addr_o  = dc_resp_addr;
  assign bus.dcache_resp_data_o  = dc_resp_data;
  assign bus.busy_o              = (state != IDLE);
  assign bus.err_o               = err;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed self-checking bench for mem_req_scheduler.
// Inputs change one time unit after the rising edge; outputs are compared
// a further time unit later, well clear of the next edge.
module tb_mem_req_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [255:0] d1, d2, d3, d6, w1, w2, junk;

  mem_req_scheduler_if #(.ADDR_W(32), .BLOCK_DW(256)) bus ();

  mem_req_scheduler #(
    .ADDR_W(32),
    .BLOCK_DW(256),
    .STARVE_LIMIT(8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts a comparison and reports a failed one.
  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives the valid/handshake inputs and lets combinational outputs settle.
  task automatic applyStimulus(input logic ic_v, input logic dc_rd_v,
                               input logic dc_wr_v, input logic gnt,
                               input logic rvalid);
    bus.icache_rd_valid_i = ic_v;
    bus.dcache_rd_valid_i = dc_rd_v;
    bus.dcache_wr_valid_i = dc_wr_v;
    bus.mem_gnt_i         = gnt;
    bus.mem_rvalid_i      = rvalid;
    #1;
  endtask

  task automatic advanceClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    d1   = {8{32'hA5A5_0001}};
    d2   = {8{32'hD2D2_0002}};
    d3   = {8{32'h1C1C_0003}};
    d6   = {8{32'h6666_0006}};
    w1   = {8{32'hBEEF_0001}};
    w2   = {8{32'hCAFE_0002}};
    junk = {8{32'hDEAD_DEAD}};

    rst = 1'b1;
    bus.icache_rd_addr_i = '0;
    bus.dcache_rd_addr_i = '0;
    bus.dcache_wr_addr_i = '0;
    bus.dcache_wr_data_i = '0;
    bus.mem_rdata_i      = '0;
    applyStimulus(0, 0, 0, 0, 0);

    // Reset state
    advanceClock();
    advanceClock();
    checkOutput("rst_mem_req", bus.mem_req_o, 0);
    checkOutput("rst_busy", bus.busy_o, 0);
    checkOutput("rst_err", bus.err_o, 0);
    checkOutput("rst_addr", bus.mem_addr_o, 0);
    rst = 1'b0;
    advanceClock();
    checkOutput("idle_no_req", bus.mem_req_o, 0);

    // Single icache read, misaligned address, grant after 5 cycles
    bus.icache_rd_addr_i = 32'h0000_1004;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("ic_ready", bus.icache_rd_ready_o, 1);
    checkOutput("ic_dc_rd_ready", bus.dcache_rd_ready_o, 0);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("ic_mem_req", bus.mem_req_o, 1);
    checkOutput("ic_mem_we", bus.mem_we_o, 0);
    checkOutput("ic_mem_addr", bus.mem_addr_o, 32'h0000_1000);
    checkOutput("ic_busy", bus.busy_o, 1);
    for (int i = 0; i < 4; i++) advanceClock();
    checkOutput("ic_req_held", bus.mem_req_o, 1);
    applyStimulus(0, 0, 0, 1, 0);
    advanceClock();
    bus.mem_rdata_i = d1;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("ic_wait_no_req", bus.mem_req_o, 0);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("ic_resp_valid", bus.icache_resp_valid_o, 1);
    checkOutput("ic_resp_data", bus.icache_resp_data_o, d1);
    checkOutput("ic_dc_resp_quiet", bus.dcache_resp_valid_o, 0);
    checkOutput("ic_err_clear", bus.err_o, 0);
    advanceClock();
    checkOutput("ic_resp_one_pulse", bus.icache_resp_valid_o, 0);

    // dcache write and read to the same block together: write first
    bus.dcache_wr_addr_i = 32'h0000_2000;
    bus.dcache_wr_data_i = w1;
    bus.dcache_rd_addr_i = 32'h0000_2000;
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("wr_first_ready", bus.dcache_wr_ready_o, 1);
    checkOutput("rd_waits_ready", bus.dcache_rd_ready_o, 0);
    advanceClock();
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("wr_mem_we", bus.mem_we_o, 1);
    checkOutput("wr_mem_addr", bus.mem_addr_o, 32'h0000_2000);
    checkOutput("wr_mem_wdata", bus.mem_wdata_o, w1);
    checkOutput("wr_no_rd_ready", bus.dcache_rd_ready_o, 0);
    applyStimulus(0, 1, 0, 1, 0);
    advanceClock();
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("wr_back_idle", bus.busy_o, 0);
    checkOutput("rd_ready_after_wr", bus.dcache_rd_ready_o, 1);
    advanceClock();
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("rd_mem_we", bus.mem_we_o, 0);
    checkOutput("rd_mem_addr", bus.mem_addr_o, 32'h0000_2000);
    advanceClock();
    bus.mem_rdata_i = d2;
    applyStimulus(0, 0, 0, 0, 1);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rd_resp_valid", bus.dcache_resp_valid_o, 1);
    checkOutput("rd_resp_addr", bus.dcache_resp_addr_o, 32'h0000_2000);
    checkOutput("rd_resp_data", bus.dcache_resp_data_o, d2);
    checkOutput("rd_ic_resp_quiet", bus.icache_resp_valid_o, 0);
    checkOutput("ic_data_held", bus.icache_resp_data_o, d1);

    // Starvation: icache waits behind 8 dcache reads, then wins
    bus.icache_rd_addr_i = 32'h0000_3008;
    bus.dcache_rd_addr_i = 32'h0000_4000;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("starve_cnt", dut.u_arb.starve_cnt, i);
      checkOutput("starve_dc_ready", bus.dcache_rd_ready_o, 1);
      checkOutput("starve_ic_ready", bus.icache_rd_ready_o, 0);
      advanceClock();
      applyStimulus(1, 1, 0, 1, 0);
      advanceClock();
      bus.mem_rdata_i = junk;
      applyStimulus(1, 1, 0, 0, 1);
      advanceClock();
    end
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("starve_cnt_sat", dut.u_arb.starve_cnt, 8);
    checkOutput("aged_ic_ready", bus.icache_rd_ready_o, 1);
    checkOutput("aged_dc_ready", bus.dcache_rd_ready_o, 0);
    advanceClock();
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("starve_cnt_clear", dut.u_arb.starve_cnt, 0);
    checkOutput("aged_mem_addr", bus.mem_addr_o, 32'h0000_3000);
    advanceClock();
    bus.mem_rdata_i = d3;
    applyStimulus(0, 0, 0, 0, 1);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("aged_ic_resp", bus.icache_resp_valid_o, 1);
    checkOutput("aged_ic_data", bus.icache_resp_data_o, d3);

    // Grant withheld for 10 cycles: request stable, no readies
    bus.dcache_wr_addr_i = 32'h0000_5010;
    bus.dcache_wr_data_i = w2;
    applyStimulus(1, 1, 1, 0, 0);
    advanceClock();
    applyStimulus(1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold_req", bus.mem_req_o, 1);
      checkOutput("hold_addr", bus.mem_addr_o, 32'h0000_5000);
      checkOutput("hold_wdata", bus.mem_wdata_o, w2);
      checkOutput("hold_readies", {bus.icache_rd_ready_o, bus.dcache_rd_ready_o,
                                   bus.dcache_wr_ready_o}, 3'b000);
      advanceClock();
    end
    applyStimulus(0, 0, 0, 1, 0);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("hold_done_idle", bus.busy_o, 0);
    checkOutput("hold_done_no_req", bus.mem_req_o, 0);

    // Spurious read data in IDLE
    bus.mem_rdata_i = junk;
    applyStimulus(0, 0, 0, 0, 1);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("spur_err", bus.err_o, 1);
    checkOutput("spur_no_ic_resp", bus.icache_resp_valid_o, 0);
    checkOutput("spur_no_dc_resp", bus.dcache_resp_valid_o, 0);
    advanceClock();
    checkOutput("spur_err_sticky", bus.err_o, 1);

    // Reset during WAIT_RD, late read data after release
    bus.icache_rd_addr_i = 32'h0000_6000;
    applyStimulus(1, 0, 0, 0, 0);
    advanceClock();
    applyStimulus(0, 0, 0, 1, 0);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wait_rd_busy", bus.busy_o, 1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", bus.busy_o, 0);
    checkOutput("midrst_err", bus.err_o, 0);
    checkOutput("midrst_mem_addr", bus.mem_addr_o, 0);
    checkOutput("midrst_ic_data", bus.icache_resp_data_o, 0);
    checkOutput("midrst_dc_addr", bus.dcache_resp_addr_o, 0);
    advanceClock();
    advanceClock();
    rst = 1'b0;
    bus.mem_rdata_i = d6;
    applyStimulus(0, 0, 0, 0, 1);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("late_no_ic_resp", bus.icache_resp_valid_o, 0);
    checkOutput("late_ic_data", bus.icache_resp_data_o, 0);
    checkOutput("late_err", bus.err_o, 1);
    checkOutput("late_idle", bus.busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
